trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 103 ++++++++++
 tb/tb_trap_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences exceptions and UART interrupts through drain, CSR capture,
// handler and mret return.
module trap_ctrl (
  input  logic        clk,
  input  logic        Rst,
  input  logic        ecall,
  input  logic        stack_mismatch,
  input  logic        uart_IRQ,
  input  logic        mret,
  input  logic        pipe_idle,
  input  logic [31:0] IF_ID_pres_addr,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        mstatus_mie,
  input  logic        mie_meie,
  output logic        trigger_trap,
  output logic [31:0] trap_mepc,
  output logic [31:0] trap_mcause,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        trapping,
  output logic        double_fault
);
  typedef enum logic [2:0] {IDLE, DRAIN, TRAP, HANDLER, RETURN} state_t;
  localparam logic [31:0] CAUSE_SM   = 32'h0000_0018;
  localparam logic [31:0] CAUSE_EC   = 32'h0000_000B;
  localparam logic [31:0] CAUSE_UART = 32'h8000_000B;
  state_t      state;
  logic        ec_pend, sm_pend;
  logic [31:0] cap_cause, cap_pc;
  logic        irq, ec_any, sm_any, latch_ok;
  logic [31:0] sel_cause, vec_pc;
  always_comb begin
    irq       = uart_IRQ & mstatus_mie & mie_meie;
    ec_any    = ec_pend | ecall;
    sm_any    = sm_pend | stack_mismatch;
    sel_cause = sm_any ? CAUSE_SM : ec_any ? CAUSE_EC : CAUSE_UART;
    latch_ok  = state != HANDLER;
    // vectored mode offsets only interrupts, by 4*cause
    vec_pc    = {mtvec[31:2], 2'b00} +
                ((cap_cause[31] && mtvec[1:0] == 2'b01) ? {25'd0, cap_cause[4:0], 2'b00} : 32'd0);
  end
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state        <= IDLE;
      ec_pend      <= 1'b0;
      sm_pend      <= 1'b0;
      cap_cause    <= '0;
      cap_pc       <= '0;
      trigger_trap <= 1'b0;
      trap_mepc    <= '0;
      trap_mcause  <= '0;
      stall        <= 1'b0;
      redirect     <= 1'b0;
      redirect_pc  <= '0;
      trapping     <= 1'b0;
      double_fault <= 1'b0;
    end else begin
      trigger_trap <= 1'b0;
      redirect     <= 1'b0;
      if (latch_ok && ecall) ec_pend <= 1'b1;
      if (latch_ok && stack_mismatch) sm_pend <= 1'b1;
      case (state)
        IDLE: if (sm_any || ec_any || irq) begin
          state     <= DRAIN;
          cap_cause <= sel_cause;
          cap_pc    <= IF_ID_pres_addr;
          stall     <= 1'b1;
        end
        DRAIN: if (pipe_idle) begin
          state        <= TRAP;
          trigger_trap <= 1'b1;
          redirect     <= 1'b1;
          redirect_pc  <= vec_pc;
          trap_mepc    <= cap_pc;
          trap_mcause  <= cap_cause;
        end
        TRAP: begin
          state    <= HANDLER;
          stall    <= 1'b0;
          trapping <= 1'b1;
          // a fresh pulse arriving while its own cause is serviced stays pending
          if (cap_cause == CAUSE_SM) sm_pend <= stack_mismatch;
          if (cap_cause == CAUSE_EC) ec_pend <= ecall;
        end
        HANDLER: begin
          if (ecall || stack_mismatch) double_fault <= 1'b1;
          if (mret) begin
            state       <= RETURN;
            redirect    <= 1'b1;
            redirect_pc <= mepc;
          end
        end
        RETURN: begin
          state    <= IDLE;
          trapping <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed stimulus with a scoreboard of expected trap/return redirects.
module tb_trap_ctrl;
  logic        clk = 0, Rst = 0;
  logic        ecall = 0, stack_mismatch = 0, uart_IRQ = 0, mret = 0, pipe_idle = 1;
  logic [31:0] IF_ID_pres_addr = 0, mtvec = 32'h200, mepc = 0;
  logic        mstatus_mie = 0, mie_meie = 0;
  logic        trigger_trap, stall, redirect, trapping, double_fault;
  logic [31:0] trap_mepc, trap_mcause, redirect_pc;
  int          checks = 0, errors = 0;
  logic [95:0] trap_q[$];
  logic [31:0] ret_q[$];

  trap_ctrl dut (
    .clk(clk), .Rst(Rst), .ecall(ecall), .stack_mismatch(stack_mismatch),
    .uart_IRQ(uart_IRQ), .mret(mret), .pipe_idle(pipe_idle),
    .IF_ID_pres_addr(IF_ID_pres_addr), .mtvec(mtvec), .mepc(mepc),
    .mstatus_mie(mstatus_mie), .mie_meie(mie_meie), .trigger_trap(trigger_trap),
    .trap_mepc(trap_mepc), .trap_mcause(trap_mcause), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .trapping(trapping),
    .double_fault(double_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ecall();
    ecall = 1;
    tick();
    ecall = 0;
  endtask

  task automatic wait_trap(input int max);
    bit seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      seen = trigger_trap;
    end
    check("trap_seen", {95'd0, seen}, 96'd1);
  endtask

  task automatic do_mret(input logic [31:0] v);
    mepc = v;
    ret_q.push_back(v);
    mret = 1;
    tick();
    mret = 0;
    check("return_trapping", {95'd0, trapping}, 96'd1);
    tick();
    check("idle_trapping", {95'd0, trapping}, 96'd0);
  endtask

  // monitor: every strobe the DUT presents is matched against the scoreboard
  initial forever begin
    @(negedge clk);
    if (trigger_trap) begin
      if (trap_q.size() == 0) check("unexpected_trap", {64'd0, trap_mcause}, 96'd0);
      else check("trap_capture", {trap_mepc, trap_mcause, redirect_pc}, trap_q.pop_front());
    end else if (redirect) begin
      if (ret_q.size() == 0) check("unexpected_redirect", {64'd0, redirect_pc}, 96'd0);
      else check("return_pc", {64'd0, redirect_pc}, {64'd0, ret_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tick(); tick();
    check("reset_outs", {91'd0, trigger_trap, stall, redirect, trapping, double_fault}, 96'd0);
    check("reset_vals", {redirect_pc, trap_mepc, trap_mcause}, 96'd0);
    Rst = 1;
    tick();

    // basic ecall
    IF_ID_pres_addr = 32'h100;
    trap_q.push_back({32'h100, 32'hB, 32'h200});
    pulse_ecall();
    check("drain_stall", {94'd0, stall, trigger_trap}, 96'd2);
    tick();
    check("trap_strobe", {93'd0, trigger_trap, stall, redirect}, 96'd7);
    tick();
    check("handler_state", {93'd0, trapping, stall, trigger_trap}, 96'd4);
    check("hold_capture", {32'd0, trap_mepc, trap_mcause}, {32'd0, 32'h100, 32'hB});
    do_mret(32'h104);

    // simultaneous stack_mismatch + ecall: stack first, ecall after mret
    IF_ID_pres_addr = 32'h300;
    trap_q.push_back({32'h300, 32'h18, 32'h200});
    ecall = 1; stack_mismatch = 1;
    tick();
    ecall = 0; stack_mismatch = 0;
    wait_trap(5);
    tick();
    IF_ID_pres_addr = 32'h400;
    trap_q.push_back({32'h400, 32'hB, 32'h200});
    do_mret(32'h304);
    wait_trap(6);
    tick();
    do_mret(32'h404);

    // UART gated by mstatus_mie, then vectored
    uart_IRQ = 1; mie_meie = 1;
    repeat (4) tick();
    check("uart_masked", {94'd0, stall, trigger_trap}, 96'd0);
    mtvec = 32'h201; mstatus_mie = 1; IF_ID_pres_addr = 32'h500;
    trap_q.push_back({32'h500, 32'h8000_000B, 32'h22C});
    wait_trap(5);
    uart_IRQ = 0;
    tick();
    do_mret(32'h504);
    mstatus_mie = 0; mtvec = 32'h200;

    // drain held by pipe_idle=0
    pipe_idle = 0; IF_ID_pres_addr = 32'h600;
    trap_q.push_back({32'h600, 32'hB, 32'h200});
    pulse_ecall();
    for (int i = 0; i < 5; i++) begin
      check("drain_hold", {94'd0, stall, trigger_trap}, 96'd2);
      tick();
    end
    pipe_idle = 1;
    tick();
    check("trap_after_idle", {95'd0, trigger_trap}, 96'd1);
    tick();
    check("trap_one_cycle", {95'd0, trigger_trap}, 96'd0);
    do_mret(32'h604);

    // double fault inside handler
    IF_ID_pres_addr = 32'h700;
    trap_q.push_back({32'h700, 32'hB, 32'h200});
    pulse_ecall();
    wait_trap(5);
    tick();
    pulse_ecall();
    check("double_fault", {94'd0, double_fault, trigger_trap}, 96'd2);
    repeat (3) tick();
    check("no_reentry", {32'd0, trap_mepc, trap_mcause}, {32'd0, 32'h700, 32'hB});
    do_mret(32'h104);
    repeat (3) tick();
    check("fault_sticky", {94'd0, double_fault, stall}, 96'd2);

    // reset in DRAIN
    pipe_idle = 0; IF_ID_pres_addr = 32'h800;
    pulse_ecall();
    check("pre_reset_stall", {95'd0, stall}, 96'd1);
    #2 Rst = 0;
    #1;
    check("async_reset", {91'd0, trigger_trap, stall, redirect, trapping, double_fault}, 96'd0);
    check("async_reset_vals", {redirect_pc, trap_mepc, trap_mcause}, 96'd0);
    #1 Rst = 1;
    pipe_idle = 1;
    repeat (5) tick();
    check("abandoned", {94'd0, stall, trigger_trap}, 96'd0);

    check("sb_empty", {64'd0, 32'(trap_q.size()), 32'(ret_q.size())}, 96'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
